// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states,
// forward-select codes and the result-source code that marks a load.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_W       = 2'b01;
    localparam logic [1:0] FWD_M       = 2'b10;
    localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The pipeline side uses
// the master modport; the hazard controller uses the slave modport.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       Rs1D, Rs2D;
    logic [4:0]       rs1_addr_E, rs2_addr_E;
    logic [4:0]       RdE, RdM, RdW;
    logic [1:0]       ResultSrcE;
    logic             RegWriteM, RegWriteW;
    logic             mispredictE;
    logic             mem_req_M, mem_ready_M;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    modport master (
        output Rs1D, Rs2D, rs1_addr_E, rs2_addr_E, RdE, RdM, RdW,
               ResultSrcE, RegWriteM, RegWriteW, mispredictE,
               mem_req_M, mem_ready_M,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE,
               ForwardAE, ForwardBE, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  Rs1D, Rs2D, rs1_addr_E, rs2_addr_E, RdE, RdM, RdW,
               ResultSrcE, RegWriteM, RegWriteW, mispredictE,
               mem_req_M, mem_ready_M,
        output StallF, StallD, StallE, StallM, FlushD, FlushE,
               ForwardAE, ForwardBE, mem_err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/fwd_sel.sv
// Execute-stage operand forward select for one source register.
// M has priority over W; x0 is never forwarded.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic [1:0] fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
            fwd = FWD_M;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
            fwd = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: stall/flush/freeze, forwarding and data-memory wait FSM.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);

    localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             mem_err_q, mem_err_d;
    logic             freeze, lw_stall;
    logic             stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
    logic [1:0]       fwd_a, fwd_b;

    fwd_sel u_fwd_a (
        .rs_e(hz.rs1_addr_E), .rd_m(hz.RdM), .rd_w(hz.RdW),
        .reg_write_m(hz.RegWriteM), .reg_write_w(hz.RegWriteW), .fwd(fwd_a)
    );

    fwd_sel u_fwd_b (
        .rs_e(hz.rs2_addr_E), .rd_m(hz.RdM), .rd_w(hz.RdW),
        .reg_write_m(hz.RegWriteM), .reg_write_w(hz.RegWriteW), .fwd(fwd_b)
    );

    assign lw_stall = (hz.ResultSrcE == RESULT_LOAD) && (hz.RdE != 5'd0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        mem_err_d = mem_err_q;
        freeze    = 1'b0;
        case (state_q)
            RUN: begin
                if (hz.mem_req_M && !hz.mem_ready_M) begin
                    freeze  = 1'b1;
                    state_d = MEM_WAIT;
                    timer_d = TMR_W'(1);
                end
            end
            MEM_WAIT: begin
                if (hz.mem_ready_M) begin
                    state_d = RUN;
                    timer_d = '0;
                end else if (timer_q >= TMR_W'(MEM_TIMEOUT - 1)) begin
                    state_d   = RUN;
                    timer_d   = '0;
                    mem_err_d = 1'b1;
                end else begin
                    freeze  = 1'b1;
                    timer_d = timer_q + TMR_W'(1);
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            timer_q   <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Reset gates the controls combinationally so they release the moment rst rises.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (rst) begin
            stall_f = 1'b0;
        end else if (freeze) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else if (hz.mispredictE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (lw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign hz.StallF    = stall_f;
    assign hz.StallD    = stall_d;
    assign hz.StallE    = stall_e;
    assign hz.StallM    = stall_m;
    assign hz.FlushD    = flush_d;
    assign hz.FlushE    = flush_e;
    assign hz.ForwardAE = rst ? FWD_RF : fwd_a;
    assign hz.ForwardBE = rst ? FWD_RF : fwd_b;
    assign hz.mem_err   = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    // Saturating counters: hold at all-ones rather than wrap.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_f && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_d && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`else
    assign hz.stall_cnt = '0;
    assign hz.flush_cnt = '0;
`endif

endmodule
